// File: rtl/phase_driver_dt_if.sv
// Gate-drive bundle between the commutation logic (master) and one half-bridge
// phase driver (slave).
interface phase_driver_dt_if #(
    parameter int unsigned DUTY_WIDTH = 9
);
    logic [DUTY_WIDTH-1:0] duty_cycle;
    logic                  high_z;
    logic                  pwm_high;
    logic                  pwm_low;
    logic                  period_start;
    logic                  in_deadtime;

    modport master (
        output duty_cycle, high_z,
        input  pwm_high, pwm_low, period_start, in_deadtime
    );

    modport slave (
        input  duty_cycle, high_z,
        output pwm_high, pwm_low, period_start, in_deadtime
    );
endinterface

// File: rtl/phase_driver_dt.sv
// Half-bridge phase driver: complementary gate PWM from a free-running carrier,
// period-latched duty, programmable dead time on every transition and high-Z override.
module phase_driver_dt #(
    parameter int unsigned DUTY_WIDTH     = 9,
    parameter int unsigned DEADTIME       = 8,
    parameter bit          CENTER_ALIGNED = 1'b0
) (
    input logic              clk,
    input logic              rst,
    phase_driver_dt_if.slave phase_io
);
    localparam logic [DUTY_WIDTH-1:0] MAX     = '1;
    localparam logic [DUTY_WIDTH-1:0] ONE     = DUTY_WIDTH'(1);
    localparam logic [7:0]            DT_LOAD = 8'(DEADTIME - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_HIGH,
        ST_LOW,
        ST_DEAD
    } state_e;

    logic [DUTY_WIDTH-1:0] cnt_q, cnt_d;
    logic [DUTY_WIDTH-1:0] shadow_q, shadow_d;
    logic                  dir_down_q, dir_down_d;
    logic                  period_start_q, period_start_d;
    logic [7:0]            dt_cnt_q, dt_cnt_d;
    state_e                state_q, state_d;
    logic                  wrap;
    logic                  want_high;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        cnt_d      = cnt_q + 1'b1;
        dir_down_d = dir_down_q;
        wrap       = 1'b0;
        if (CENTER_ALIGNED) begin
            if (!dir_down_q) begin
                if (cnt_q == MAX) begin
                    cnt_d      = cnt_q - 1'b1;
                    dir_down_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == ONE) begin
                    dir_down_d = 1'b0;
                    wrap       = 1'b1;
                end
            end
        end else begin
            wrap = (cnt_q == MAX);
        end
        // wrap marks the edge on which the carrier returns to zero
        shadow_d       = wrap ? phase_io.duty_cycle : shadow_q;
        period_start_d = wrap;
    end

    assign want_high = (shadow_q == MAX) || (cnt_q < shadow_q);

    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        case (state_q)
            ST_OFF: begin
                state_d  = ST_DEAD;
                dt_cnt_d = DT_LOAD;
            end
            ST_HIGH: begin
                if (!want_high) begin
                    state_d  = ST_DEAD;
                    dt_cnt_d = DT_LOAD;
                end
            end
            ST_LOW: begin
                if (want_high) begin
                    state_d  = ST_DEAD;
                    dt_cnt_d = DT_LOAD;
                end
            end
            ST_DEAD: begin
                if (dt_cnt_q != '0) begin
                    dt_cnt_d = dt_cnt_q - 1'b1;
                end else begin
                    state_d = want_high ? ST_HIGH : ST_LOW;
                end
            end
            default: state_d = ST_OFF;
        endcase
        // Floating the phase overrides everything, including an unfinished dead time.
        if (phase_io.high_z) begin
            state_d = ST_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            shadow_q       <= '0;
            dir_down_q     <= 1'b0;
            period_start_q <= 1'b0;
            dt_cnt_q       <= '0;
            state_q        <= ST_OFF;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            dir_down_q     <= dir_down_d;
            period_start_q <= period_start_d;
            dt_cnt_q       <= dt_cnt_d;
            state_q        <= state_d;
        end
    end

    assign phase_io.pwm_high     = (state_q == ST_HIGH);
    assign phase_io.pwm_low      = (state_q == ST_LOW);
    assign phase_io.in_deadtime  = (state_q == ST_DEAD);
    assign phase_io.period_start = period_start_q;
endmodule
